// File: rtl/bsg_countdown_timer.sv
// Handshaked countdown stage: loads a length, decrements to zero, then holds a done token.
// Optional one-entry request skid buffer enabled with BSG_COUNTDOWN_TIMER_SKID_EN.
module bsg_countdown_timer #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] len_i,
  output logic               ready_o,
  output logic               v_o,
  input  logic               yumi_i,
  input  logic               abort_i,
  output logic               busy_o,
  output logic [width_p-1:0] count_o
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e             state_r, state_n;
  logic [width_p-1:0] count_r, count_n;
  logic               hs;

`ifdef BSG_COUNTDOWN_TIMER_SKID_EN
  logic               buf_v_r, buf_v_n;
  logic [width_p-1:0] buf_len_r, buf_len_n;

  // Accepting while busy parks the request; abort blocks acceptance since it flushes the buffer.
  assign ready_o = ~buf_v_r & ~abort_i;
`else
  assign ready_o = (state_r == IDLE);
`endif

  assign hs      = v_i & ready_o;
  assign v_o     = (state_r == DONE);
  assign busy_o  = (state_r != IDLE);
  assign count_o = count_r;

  always_comb begin
    state_n = state_r;
    count_n = count_r;
`ifdef BSG_COUNTDOWN_TIMER_SKID_EN
    buf_v_n   = buf_v_r;
    buf_len_n = buf_len_r;
`endif
    unique case (state_r)
      IDLE: begin
        if (hs) begin
          count_n = len_i;
          state_n = (len_i != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_n = IDLE;
          count_n = '0;
`ifdef BSG_COUNTDOWN_TIMER_SKID_EN
          buf_v_n = 1'b0;
`endif
        end else begin
          count_n = count_r - width_p'(1);
          if (count_r == width_p'(1)) state_n = DONE;
`ifdef BSG_COUNTDOWN_TIMER_SKID_EN
          if (hs) begin
            buf_v_n   = 1'b1;
            buf_len_n = len_i;
          end
`endif
        end
      end
      DONE: begin
        if (abort_i) begin
          state_n = IDLE;
          count_n = '0;
`ifdef BSG_COUNTDOWN_TIMER_SKID_EN
          buf_v_n = 1'b0;
`endif
        end else if (yumi_i) begin
`ifdef BSG_COUNTDOWN_TIMER_SKID_EN
          // Chain straight into the next request, from the buffer or bypassing len_i.
          if (buf_v_r) begin
            count_n = buf_len_r;
            state_n = (buf_len_r != '0) ? RUN : DONE;
            buf_v_n = 1'b0;
          end else if (hs) begin
            count_n = len_i;
            state_n = (len_i != '0) ? RUN : DONE;
          end else begin
            state_n = IDLE;
          end
`else
          state_n = IDLE;
`endif
        end else begin
`ifdef BSG_COUNTDOWN_TIMER_SKID_EN
          if (hs) begin
            buf_v_n   = 1'b1;
            buf_len_n = len_i;
          end
`endif
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      count_r <= '0;
`ifdef BSG_COUNTDOWN_TIMER_SKID_EN
      buf_v_r   <= 1'b0;
      buf_len_r <= '0;
`endif
    end else begin
      state_r <= state_n;
      count_r <= count_n;
`ifdef BSG_COUNTDOWN_TIMER_SKID_EN
      buf_v_r   <= buf_v_n;
      buf_len_r <= buf_len_n;
`endif
    end
  end

endmodule

// File: tb/tb_bsg_countdown_timer.sv
// Self-checking bench for bsg_countdown_timer (base build): directed cases plus randomized
// traffic compared every cycle against an elapsed-time model of the countdown.
module tb_bsg_countdown_timer;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b0;
  logic        v_i = 1'b0;
  logic [15:0] len_i = '0;
  logic        ready_o;
  logic        v_o;
  logic        yumi_i = 1'b0;
  logic        abort_i = 1'b0;
  logic        busy_o;
  logic [15:0] count_o;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  // Model: a request is "loaded" from its accepting edge; m_e counts edges since then.
  bit m_loaded = 1'b0;
  int m_len = 0;
  int m_e = 0;

  bsg_countdown_timer #(.width_p(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .v_i(v_i), .len_i(len_i), .ready_o(ready_o),
    .v_o(v_o), .yumi_i(yumi_i), .abort_i(abort_i), .busy_o(busy_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit m_vo();
    return m_loaded && (m_e >= m_len);
  endfunction

  function automatic logic [15:0] m_count();
    if (!m_loaded || m_e >= m_len) return 16'd0;
    return 16'(m_len - m_e);
  endfunction

  always @(posedge clk_i) begin
    if (reset_i) begin
      m_loaded = 1'b0;
    end else if (m_loaded) begin
      if (abort_i) m_loaded = 1'b0;
      else if (m_e >= m_len) begin
        if (yumi_i) m_loaded = 1'b0;
      end else m_e = m_e + 1;
    end else if (v_i) begin
      m_loaded = 1'b1;
      m_len    = int'(len_i);
      m_e      = 0;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_i) begin
    if (cmp_en) begin
      check_output("model_v_o", 32'(v_o), 32'(m_vo()));
      check_output("model_busy_o", 32'(busy_o), 32'(m_loaded));
      check_output("model_ready_o", 32'(ready_o), 32'(!m_loaded));
      check_output("model_count_o", 32'(count_o), 32'(m_count()));
      if (yumi_i) check_output("yumi_legal_v_o", 32'(v_o), 32'd1);
    end
  end

  task automatic apply_stimulus(input bit v, input logic [15:0] len, input bit yumi,
                                input bit abort, input bit rst);
    v_i = v; len_i = len; yumi_i = yumi; abort_i = abort; reset_i = rst;
    @(posedge clk_i);
    #1;
    v_i = 1'b0; len_i = '0; yumi_i = 1'b0; abort_i = 1'b0; reset_i = 1'b0;
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_count"}, 32'(count_o), 32'd0);
    check_output({tag, "_v_o"}, 32'(v_o), 32'd0);
    check_output({tag, "_busy"}, 32'(busy_o), 32'd0);
    check_output({tag, "_ready"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    int n;
    logic [15:0] exp_seq [5];
    exp_seq = '{16'd5, 16'd4, 16'd3, 16'd2, 16'd1};

    apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    cmp_en = 1'b1;
    check_reset_values("reset");

    // len=5 walk, token hold, release
    apply_stimulus(1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_output("len5_count", 32'(count_o), 32'(exp_seq[i]));
      check_output("len5_v_o_low", 32'(v_o), 32'd0);
      idle_cycle();
    end
    for (int i = 0; i < 4; i++) begin
      check_output("len5_v_o_hold", 32'(v_o), 32'd1);
      check_output("len5_count_zero", 32'(count_o), 32'd0);
      if (i < 3) idle_cycle();
    end
    apply_stimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    check_reset_values("after_yumi");

    // len=0 enters DONE at the accepting edge; len=1 after one counting cycle
    apply_stimulus(1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
    check_output("len0_v_o", 32'(v_o), 32'd1);
    apply_stimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    apply_stimulus(1'b1, 16'd1, 1'b0, 1'b0, 1'b0);
    check_output("len1_count", 32'(count_o), 32'd1);
    check_output("len1_v_o_low", 32'(v_o), 32'd0);
    idle_cycle();
    check_output("len1_v_o", 32'(v_o), 32'd1);
    apply_stimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);

    // full-range count
    apply_stimulus(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    check_output("ffff_first_count", 32'(count_o), 32'hFFFF);
    n = 0;
    while (v_o !== 1'b1 && n < 70000) begin
      idle_cycle();
      n++;
    end
    check_output("ffff_latency", 32'(n), 32'd65535);
    apply_stimulus(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);

    // abort mid-count, then a normal request, then abort+yumi in DONE
    apply_stimulus(1'b1, 16'd6, 1'b0, 1'b0, 1'b0);
    repeat (3) idle_cycle();
    check_output("abort_pre_count", 32'(count_o), 32'd3);
    apply_stimulus(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    check_reset_values("abort_run");
    apply_stimulus(1'b1, 16'd2, 1'b0, 1'b0, 1'b0);
    check_output("post_abort_count2", 32'(count_o), 32'd2);
    idle_cycle();
    check_output("post_abort_count1", 32'(count_o), 32'd1);
    idle_cycle();
    check_output("post_abort_v_o", 32'(v_o), 32'd1);
    apply_stimulus(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    check_reset_values("abort_yumi");
    idle_cycle();
    check_output("abort_yumi_no_token", 32'(v_o), 32'd0);

    // reset in RUN and in DONE
    apply_stimulus(1'b1, 16'd9, 1'b0, 1'b0, 1'b0);
    repeat (2) idle_cycle();
    check_output("reset_run_pre_count", 32'(count_o), 32'd7);
    apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    check_reset_values("reset_run");
    apply_stimulus(1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
    check_output("reset_done_pre_v_o", 32'(v_o), 32'd1);
    apply_stimulus(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    check_reset_values("reset_done");

    // randomized traffic, checked each cycle by the model
    for (int i = 0; i < 600; i++) begin
      bit rv, ry, ra, rr;
      logic [15:0] rl;
      rv = 1'($urandom_range(0, 1));
      rl = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 40)) : 16'($urandom_range(0, 4));
      ry = m_vo() && ($urandom_range(0, 2) != 0);
      ra = ($urandom_range(0, 15) == 0);
      rr = ($urandom_range(0, 63) == 0);
      apply_stimulus(rv, rl, ry, ra, rr);
    end

    idle_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
